// File: rtl/stim_blank_scheduler_if.sv
// Control and status bundle for the stimulus/blanking scheduler.
// Signal names follow the scheduler's external pin names.
interface stim_blank_scheduler_if;
  localparam int unsigned CH_W  = 2;
  localparam int unsigned MAG_W = 5;

  logic             ENABLE;
  logic             CH_SWEEP;
  logic             RAMP;
  logic [MAG_W-1:0] MAG_TGT;
  logic             EN_ST;
  logic             CAT_ST;
  logic             ANO_ST;
  logic             DIS_ST;
  logic [CH_W-1:0]  CH_SEL_ST;
  logic [MAG_W-1:0] MAG_ST;
  logic             BLANK_EMG;
  logic             PULSE_DONE;

  modport master (
    output ENABLE, CH_SWEEP, RAMP, MAG_TGT,
    input  EN_ST, CAT_ST, ANO_ST, DIS_ST, CH_SEL_ST, MAG_ST, BLANK_EMG, PULSE_DONE
  );

  modport slave (
    input  ENABLE, CH_SWEEP, RAMP, MAG_TGT,
    output EN_ST, CAT_ST, ANO_ST, DIS_ST, CH_SEL_ST, MAG_ST, BLANK_EMG, PULSE_DONE
  );
endinterface

// File: rtl/stim_blank_scheduler.sv
// Biphasic stimulus pulse scheduler with EMG blanking window, channel sweep
// and magnitude ramp. Every output is driven directly by a flop.
module stim_blank_scheduler #(
  parameter int unsigned PERIOD     = 500,
  parameter int unsigned BLANK_PRE  = 5,
  parameter int unsigned CAT_PH     = 150,
  parameter int unsigned IPD        = 10,
  parameter int unsigned ANO_PH     = 150,
  parameter int unsigned DIS_PH     = 10,
  parameter int unsigned BLANK_POST = 50,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DUR_CH     = 5,
  parameter int unsigned MAG_MIN    = 1
) (
  input logic                  CLK,
  input logic                  RESETN,
  stim_blank_scheduler_if.slave bus
);

  localparam int unsigned PCNT_W = $clog2(PERIOD);
  localparam int unsigned DUR_W  = $clog2(DUR_CH + 1);
  localparam int unsigned CH_W   = 2;
  localparam int unsigned MAG_W  = 5;

  // Period-relative start points of each phase
  localparam int unsigned T_CAT       = BLANK_PRE;
  localparam int unsigned T_GAP       = T_CAT + CAT_PH;
  localparam int unsigned T_ANO       = T_GAP + IPD;
  localparam int unsigned T_DIS       = T_ANO + ANO_PH;
  localparam int unsigned T_REST      = T_DIS + DIS_PH;
  localparam int unsigned T_BLANK_END = T_REST + BLANK_POST;

  generate
    if (T_BLANK_END >= PERIOD || NUM_CH > 4 || NUM_CH < 1 || DUR_CH < 1 ||
        BLANK_PRE < 1 || CAT_PH < 1 || IPD < 1 || ANO_PH < 1 || DIS_PH < 1 ||
        BLANK_POST < 1) begin : g_bad_params
      $error("stim_blank_scheduler: illegal timing parameters");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, PRE, CAT, GAP, ANO, DIS, REST} state_t;

  state_t             state_q, state_d;
  logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
  logic [DUR_W-1:0]   cnt_q, cnt_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [MAG_W-1:0]   mag_q, mag_d;
  logic               en_q, en_d;
  logic               cat_q, cat_d;
  logic               ano_q, ano_d;
  logic               dis_q, dis_d;
  logic               blank_q, blank_d;
  logic               done_q, done_d;
  logic               start_run, start_period;

  always_comb begin
    state_d      = state_q;
    pcnt_d       = pcnt_q;
    cnt_d        = cnt_q;
    ch_d         = ch_q;
    mag_d        = mag_q;
    start_run    = 1'b0;
    start_period = 1'b0;

    unique case (state_q)
      IDLE: if (bus.ENABLE) state_d = PRE;
      PRE:  if (pcnt_q == PCNT_W'(T_GAP - CAT_PH - 1)) state_d = CAT;
      CAT:  if (pcnt_q == PCNT_W'(T_GAP - 1))  state_d = GAP;
      GAP:  if (pcnt_q == PCNT_W'(T_ANO - 1))  state_d = ANO;
      ANO:  if (pcnt_q == PCNT_W'(T_DIS - 1))  state_d = DIS;
      DIS:  if (pcnt_q == PCNT_W'(T_REST - 1)) state_d = REST;
      REST: if (pcnt_q == PCNT_W'(PERIOD - 1)) state_d = bus.ENABLE ? PRE : IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q == IDLE || pcnt_q == PCNT_W'(PERIOD - 1)) pcnt_d = '0;
    else                                                  pcnt_d = pcnt_q + PCNT_W'(1);

    start_run    = (state_q == IDLE) && (state_d == PRE);
    start_period = (state_q == REST) && (state_d == PRE);
    done_d       = (state_q == DIS) && (state_d == REST);

    // Pulse counting and channel advance happen as the pulse completes (in REST)
    if (start_run) begin
      cnt_d = '0;
    end else if (done_d) begin
      if (cnt_q == DUR_W'(DUR_CH - 1)) begin
        cnt_d = '0;
        if (bus.CH_SWEEP) ch_d = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
      end else begin
        cnt_d = cnt_q + DUR_W'(1);
      end
    end

    // Magnitude only moves at PRE entry so a pulse never sees a change
    if (start_run) begin
      mag_d = (bus.RAMP && bus.MAG_TGT >= MAG_W'(MAG_MIN)) ? MAG_W'(MAG_MIN) : bus.MAG_TGT;
    end else if (start_period) begin
      mag_d = (bus.RAMP && mag_q < bus.MAG_TGT) ? mag_q + MAG_W'(1) : bus.MAG_TGT;
    end

    en_d    = (state_d == PRE) || (state_d == CAT) || (state_d == GAP) ||
              (state_d == ANO) || (state_d == DIS);
    cat_d   = (state_d == CAT);
    ano_d   = (state_d == ANO);
    dis_d   = (state_d == DIS);
    blank_d = (state_d != IDLE) &&
              !((state_d == REST) && (pcnt_d >= PCNT_W'(T_BLANK_END)));
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      cnt_q   <= '0;
      ch_q    <= '0;
      mag_q   <= '0;
      en_q    <= 1'b0;
      cat_q   <= 1'b0;
      ano_q   <= 1'b0;
      dis_q   <= 1'b0;
      blank_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      mag_q   <= mag_d;
      en_q    <= en_d;
      cat_q   <= cat_d;
      ano_q   <= ano_d;
      dis_q   <= dis_d;
      blank_q <= blank_d;
      done_q  <= done_d;
    end
  end

  assign bus.EN_ST      = en_q;
  assign bus.CAT_ST     = cat_q;
  assign bus.ANO_ST     = ano_q;
  assign bus.DIS_ST     = dis_q;
  assign bus.CH_SEL_ST  = ch_q;
  assign bus.MAG_ST     = mag_q;
  assign bus.BLANK_EMG  = blank_q;
  assign bus.PULSE_DONE = done_q;

endmodule

// File: tb/tb_stim_blank_scheduler.sv
// Directed bench for stim_blank_scheduler with short timing parameters
// (40-cycle period, pulse occupying pcnt 0..15, blank through pcnt 19).
module tb_stim_blank_scheduler;

  logic CLK = 1'b0;
  logic RESETN = 1'b0;

  stim_blank_scheduler_if bus ();

  stim_blank_scheduler #(
    .PERIOD(40), .BLANK_PRE(2), .CAT_PH(5), .IPD(2), .ANO_PH(5), .DIS_PH(2),
    .BLANK_POST(4), .NUM_CH(4), .DUR_CH(2), .MAG_MIN(1)
  ) dut (
    .CLK   (CLK),
    .RESETN(RESETN),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int n_viol   = 0;

  logic [5:0] flags;
  assign flags = {bus.EN_ST, bus.CAT_ST, bus.ANO_ST, bus.DIS_ST, bus.PULSE_DONE, bus.BLANK_EMG};

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Hand-derived {EN,CAT,ANO,DIS,DONE,BLANK} for each pcnt of an active period
  function automatic int unsigned exp_flags(input int p);
    logic en, cat, ano, dis, done, blank;
    en    = (p <= 15);
    cat   = (p >= 2) && (p <= 6);
    ano   = (p >= 9) && (p <= 13);
    dis   = (p == 14) || (p == 15);
    done  = (p == 16);
    blank = (p <= 19);
    return int'({en, cat, ano, dis, done, blank});
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Invariant monitor: phase exclusivity and no CH/MAG change inside a pulse
  logic             prev_en = 1'b0;
  logic [1:0]       prev_ch = '0;
  logic [4:0]       prev_mag = '0;
  always @(negedge CLK) begin
    if (RESETN) begin
      if (!bus.EN_ST && (bus.CAT_ST || bus.ANO_ST || bus.DIS_ST)) n_viol++;
      if (int'(bus.CAT_ST) + int'(bus.ANO_ST) + int'(bus.DIS_ST) > 1) n_viol++;
      if (bus.EN_ST && prev_en && (bus.CH_SEL_ST != prev_ch || bus.MAG_ST != prev_mag)) n_viol++;
    end
    prev_en  = bus.EN_ST;
    prev_ch  = bus.CH_SEL_ST;
    prev_mag = bus.MAG_ST;
  end

  int unsigned exp_ch_sweep [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int unsigned exp_mag_ramp [4] = '{1, 2, 3, 3};

  initial begin
    bus.ENABLE   = 1'b0;
    bus.CH_SWEEP = 1'b0;
    bus.RAMP     = 1'b0;
    bus.MAG_TGT  = 5'd0;

    // Reset state, then idle with ENABLE low
    step(2);
    check("reset_flags", flags, 0);
    check("reset_ch", bus.CH_SEL_ST, 0);
    check("reset_mag", bus.MAG_ST, 0);
    RESETN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("idle_no_enable", flags, 0);
    end

    // Two fixed-magnitude periods; target change mid-pulse waits for next PRE
    bus.ENABLE  = 1'b1;
    bus.MAG_TGT = 5'd10;
    for (int k = 0; k < 80; k++) begin
      step(1);
      check("pattern", flags, exp_flags(k % 40));
      if (k == 0)  check("mag_fixed", bus.MAG_ST, 10);
      if (k == 0)  check("ch_start", bus.CH_SEL_ST, 0);
      if (k == 45) bus.MAG_TGT = 5'd12;
      if (k == 60) check("mag_held_midpulse", bus.MAG_ST, 10);
      if (k == 79) check("ch_no_sweep", bus.CH_SEL_ST, 0);
    end

    // Channel sweep over nine periods
    bus.CH_SWEEP = 1'b1;
    for (int p = 0; p < 9; p++) begin
      step(6);
      check("ch_sweep", bus.CH_SEL_ST, exp_ch_sweep[p]);
      if (p == 0) check("mag_new_tgt", bus.MAG_ST, 12);
      step(34);
    end

    // ENABLE drops during CAT: pulse and blanking tail still complete
    step(4);
    bus.ENABLE = 1'b0;
    for (int p = 4; p < 40; p++) begin
      step(1);
      check("drop_pattern", flags, exp_flags(p));
    end
    step(1);
    check("stopped_flags", flags, 0);
    check("stopped_ch", bus.CH_SEL_ST, 1);
    step(1);
    check("stopped_flags2", flags, 0);

    // Ramp from IDLE: magnitude 1,2,3,3; channel kept over restart
    bus.RAMP    = 1'b1;
    bus.MAG_TGT = 5'd3;
    bus.ENABLE  = 1'b1;
    for (int q = 0; q < 4; q++) begin
      step(6);
      check("mag_ramp", bus.MAG_ST, exp_mag_ramp[q]);
      if (q == 0) check("ch_kept_restart", bus.CH_SEL_ST, 1);
      if (q == 2) check("ch_after_restart", bus.CH_SEL_ST, 2);
      step(34);
    end

    // Asynchronous reset during ANO
    step(11);
    check("pre_reset_ano", flags, exp_flags(10));
    RESETN = 1'b0;
    #1;
    check("async_reset_flags", flags, 0);
    check("async_reset_ch", bus.CH_SEL_ST, 0);
    check("async_reset_mag", bus.MAG_ST, 0);
    step(2);
    RESETN = 1'b1;
    step(1);
    check("restart_pre", flags, exp_flags(0));
    check("restart_mag", bus.MAG_ST, 1);
    check("restart_ch", bus.CH_SEL_ST, 0);
    step(2);
    check("restart_cat", flags, exp_flags(2));

    step(1);
    check("invariants", n_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
